acc_loader: RTL and testbench

Upstream/downstream companion to the matrix-multiply accelerator top. Accepts 32-bit words from the core-side streaming interface and packs them into the two 1024-byte operand buffers (A, B). Pulses the accelerator start, waits for done, then streams the 1024-byte result back as 32-bit words. Sits between the core's data mover and the accelerator top, owning all sequencing.

---
 rtl/acc_pkg.sv | 40 ++++
 rtl/acc_buf_writer.sv | 65 ++++++
 rtl/acc_loader.sv | 204 ++++++++++++++++++++
 tb/tb_acc_loader.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/acc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : acc_pkg
//  Description : Shared constants, types and helpers for the accelerator
//                loader. Buffer geometry, the sequencing-state encoding and a
//                word-extraction helper for little-endian byte buffers.
//  Revision    : 1.0  initial release
// ============================================================================
package acc_pkg;

  localparam int BUF_BYTES  = 1024;
  localparam int WORD_W     = 32;
  localparam int WORD_BYTES = 4;
  localparam int WORDS      = BUF_BYTES / WORD_BYTES;
  localparam int PTR_W      = $clog2(WORDS);

  typedef logic [BUF_BYTES-1:0][7:0] acc_buf_t;

  // Sequencer state encoding, kept as plain constants so the state register
  // stays a bare logic vector in netlists and waveforms.
  localparam logic [1:0] ST_LOAD  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  typedef enum logic [1:0] {
    LOAD  = ST_LOAD,
    START = ST_START,
    WAIT  = ST_WAIT,
    DRAIN = ST_DRAIN
  } acc_ld_state_e;

  // Word idx of a byte buffer: byte 4*idx lands in bits [7:0].
  function automatic logic [WORD_W-1:0] word_sel(input acc_buf_t b,
                                                 input logic [PTR_W-1:0] idx);
    return b[{idx, 2'b00} +: WORD_BYTES];
  endfunction

endpackage
`default_nettype wire

// File: rtl/acc_buf_writer.sv
`default_nettype none
// ============================================================================
//  Module      : acc_buf_writer
//  Description : One operand buffer. Packs accepted 32-bit words into the
//                1024-byte store at the running word pointer (little-endian),
//                and raises a full flag on the 256th word or on a last word.
//  Ports       : clk, rst        - clock, async active-high reset
//                we              - word accepted this cycle
//                wdata, wlast    - word and its last marker
//                clr             - clear pointer and full flag (contents kept)
//                full_next       - next-cycle value of the full flag
//                mem_out         - buffer contents (registered)
//  Revision    : 1.0  initial release
// ============================================================================
module acc_buf_writer
  import acc_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      we,
  input  logic [WORD_W-1:0]         wdata,
  input  logic                      wlast,
  input  logic                      clr,
  output logic                      full_next,
  output logic [BUF_BYTES-1:0][7:0] mem_out
);

  logic [PTR_W-1:0]          ptr_q, ptr_d;
  logic                      full_q, full_d;
  logic [BUF_BYTES-1:0][7:0] mem_q, mem_d;

  always_comb begin
    ptr_d  = ptr_q;
    full_d = full_q;
    mem_d  = mem_q;
    if (clr) begin
      // Only the bookkeeping is cleared; stale bytes stay in place.
      ptr_d  = '0;
      full_d = 1'b0;
    end else if (we) begin
      mem_d[{ptr_q, 2'b00} +: WORD_BYTES] = wdata;
      ptr_d = ptr_q + 1'b1;
      if (wlast || (ptr_q == PTR_W'(WORDS - 1))) begin
        full_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q  <= '0;
      full_q <= 1'b0;
      mem_q  <= '0;
    end else begin
      ptr_q  <= ptr_d;
      full_q <= full_d;
      mem_q  <= mem_d;
    end
  end

  assign full_next = full_d;
  assign mem_out   = mem_q;

endmodule
`default_nettype wire

// File: rtl/acc_loader.sv
`default_nettype none
// ============================================================================
//  Module      : acc_loader
//  Description : Sequencer between the core data mover and the matrix-multiply
//                accelerator. Loads operand buffers A and B from a 32-bit
//                write stream, pulses acc_start, waits for acc_done, then
//                streams the 1024-byte result back as 32-bit words.
//  Ports       : clk, rst                         - clock, async active-high reset
//                wr_valid/wr_ready/wr_sel/wr_data/wr_last - operand write stream
//                rd_valid/rd_ready/rd_data/rd_last        - result read stream
//                busy       - high whenever not loading
//                evt_done   - pulse after the final result word is accepted
//                acc_start  - one-cycle start pulse to the accelerator
//                acc_done   - accelerator completion level
//                acc_in_A, acc_in_B - operand buffers
//                acc_out    - accelerator result bytes
//  Config      : ACC_LOADER_RESULT_BUF_EN - when defined, acc_out is captured
//                into a local result register on the acc_done edge; when
//                undefined, the read stream muxes acc_out directly.
//  Revision    : 1.0  initial release
// ============================================================================
module acc_loader
  import acc_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_valid,
  output logic                      wr_ready,
  input  logic                      wr_sel,
  input  logic [31:0]               wr_data,
  input  logic                      wr_last,
  output logic                      rd_valid,
  input  logic                      rd_ready,
  output logic [31:0]               rd_data,
  output logic                      rd_last,
  output logic                      busy,
  output logic                      evt_done,
  output logic                      acc_start,
  input  logic                      acc_done,
  output logic [BUF_BYTES-1:0][7:0] acc_in_A,
  output logic [BUF_BYTES-1:0][7:0] acc_in_B,
  input  logic [BUF_BYTES-1:0][7:0] acc_out
);

  logic [1:0]       state_q, state_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic             rdy_a_q, rdy_a_d;
  logic             rdy_b_q, rdy_b_d;
  logic             rd_valid_q, rd_valid_d;
  logic [31:0]      rd_data_q, rd_data_d;
  logic             rd_last_q, rd_last_d;
  logic             evt_done_q, evt_done_d;
  logic             acc_start_q, acc_start_d;
  logic             busy_q, busy_d;

  logic             wr_accept;
  logic             we_a, we_b;
  logic             full_a_next, full_b_next;
  logic             rd_hs;
  logic             final_hs;
  acc_buf_t         result_src;

  // Per-buffer ready flags are registered; the select input only picks which
  // one is presented, so a full A never blocks words headed for B.
  assign wr_ready  = wr_sel ? rdy_b_q : rdy_a_q;
  assign wr_accept = wr_valid && wr_ready;
  assign we_a      = wr_accept && !wr_sel;
  assign we_b      = wr_accept &&  wr_sel;

  assign rd_hs     = rd_valid_q && rd_ready;
  assign final_hs  = rd_hs && rd_last_q;

  acc_buf_writer u_buf_a (
    .clk       (clk),
    .rst       (rst),
    .we        (we_a),
    .wdata     (wr_data),
    .wlast     (wr_last),
    .clr       (final_hs),
    .full_next (full_a_next),
    .mem_out   (acc_in_A)
  );

  acc_buf_writer u_buf_b (
    .clk       (clk),
    .rst       (rst),
    .we        (we_b),
    .wdata     (wr_data),
    .wlast     (wr_last),
    .clr       (final_hs),
    .full_next (full_b_next),
    .mem_out   (acc_in_B)
  );

`ifdef ACC_LOADER_RESULT_BUF_EN
  acc_buf_t result_q, result_d;

  always_comb begin
    result_d = result_q;
    if ((state_q == ST_WAIT) && acc_done) begin
      result_d = acc_out;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q <= '0;
    end else begin
      result_q <= result_d;
    end
  end

  assign result_src = result_q;
`else
  assign result_src = acc_out;
`endif

  // Sequencer. Every output flop is loaded from the next-state view so each
  // output changes on the same edge as the state that defines it.
  always_comb begin
    state_d    = state_q;
    rptr_d     = rptr_q;
    rd_data_d  = rd_data_q;
    evt_done_d = 1'b0;

    case (state_q)
      ST_LOAD: begin
        if (full_a_next && full_b_next) begin
          state_d = ST_START;
        end
      end
      ST_START: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (acc_done) begin
          state_d   = ST_DRAIN;
          rptr_d    = '0;
          // Word 0 comes straight from acc_out: the optional result register
          // is only being loaded on this same edge.
          rd_data_d = word_sel(acc_out, '0);
        end
      end
      ST_DRAIN: begin
        if (rd_hs) begin
          if (rd_last_q) begin
            state_d    = ST_LOAD;
            rptr_d     = '0;
            rd_data_d  = '0;
            evt_done_d = 1'b1;
          end else begin
            rptr_d    = rptr_q + 1'b1;
            rd_data_d = word_sel(result_src, rptr_d);
          end
        end
      end
      default: begin
        state_d = ST_LOAD;
      end
    endcase

    rd_valid_d  = (state_d == ST_DRAIN);
    rd_last_d   = (state_d == ST_DRAIN) && (rptr_d == PTR_W'(WORDS - 1));
    acc_start_d = (state_d == ST_START);
    busy_d      = (state_d != ST_LOAD);
    rdy_a_d     = (state_d == ST_LOAD) && !full_a_next;
    rdy_b_d     = (state_d == ST_LOAD) && !full_b_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_LOAD;
      rptr_q      <= '0;
      rdy_a_q     <= 1'b0;
      rdy_b_q     <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
      rd_last_q   <= 1'b0;
      evt_done_q  <= 1'b0;
      acc_start_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rptr_q      <= rptr_d;
      rdy_a_q     <= rdy_a_d;
      rdy_b_q     <= rdy_b_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
      rd_last_q   <= rd_last_d;
      evt_done_q  <= evt_done_d;
      acc_start_q <= acc_start_d;
      busy_q      <= busy_d;
    end
  end

  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;
  assign rd_last   = rd_last_q;
  assign evt_done  = evt_done_q;
  assign acc_start = acc_start_q;
  assign busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_acc_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_acc_loader
//  Description : Self-checking bench for acc_loader. Operand buffers are
//                checked against a byte model; result words are pushed to a
//                scoreboard queue when the accelerator stub drives acc_out
//                and popped as the read stream hands them over.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_acc_loader;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              wr_valid = 1'b0;
  logic              wr_ready;
  logic              wr_sel = 1'b0;
  logic [31:0]       wr_data = '0;
  logic              wr_last = 1'b0;
  logic              rd_valid;
  logic              rd_ready = 1'b0;
  logic [31:0]       rd_data;
  logic              rd_last;
  logic              busy;
  logic              evt_done;
  logic              acc_start;
  logic              acc_done = 1'b0;
  logic [1023:0][7:0] acc_in_A;
  logic [1023:0][7:0] acc_in_B;
  logic [1023:0][7:0] acc_out = '0;

  int tests = 0;
  int fails = 0;
  int stall_cnt = 0;
  int mptr_a = 0;
  int mptr_b = 0;
  logic [1023:0][7:0] model_a = '0;
  logic [1023:0][7:0] model_b = '0;
  logic [31:0] exp_q[$];

  acc_loader dut (
    .clk       (clk),
    .rst       (rst),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_sel    (wr_sel),
    .wr_data   (wr_data),
    .wr_last   (wr_last),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .rd_data   (rd_data),
    .rd_last   (rd_last),
    .busy      (busy),
    .evt_done  (evt_done),
    .acc_start (acc_start),
    .acc_done  (acc_done),
    .acc_in_A  (acc_in_A),
    .acc_in_B  (acc_in_B),
    .acc_out   (acc_out)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] pat_a(input int k);
    return {4{k[7:0]}} + 32'h01020304;
  endfunction

  function automatic logic [31:0] pat_b(input int k, input int s);
    return {4{k[7:0]}} ^ (32'h5A3C0F96 + s);
  endfunction

  // Drive one word and wait (bounded) for its handshake; returns at the
  // falling edge after the accepting rising edge. Updates the byte model.
  task automatic put_word(input logic sel, input logic [31:0] d, input logic last);
    int t = 0;
    wr_valid = 1'b1; wr_sel = sel; wr_data = d; wr_last = last;
    #1;
    while (wr_ready !== 1'b1 && t < 50) begin
      @(negedge clk); #1; t++;
    end
    if (t > 0) stall_cnt++;
    tests++;
    if (t >= 50) begin
      fails++;
      $display("FAIL wr_handshake_timeout: wr_ready=%b after %0d cycles, required 1", wr_ready, t);
    end
    @(negedge clk);
    wr_valid = 1'b0; wr_last = 1'b0;
    if (sel == 1'b0) begin
      if (mptr_a < 256) model_a[mptr_a*4 +: 4] = d;
      mptr_a++;
    end else begin
      if (mptr_b < 256) model_b[mptr_b*4 +: 4] = d;
      mptr_b++;
    end
  endtask

  task automatic load_full(input int s);
    for (int k = 0; k < 256; k++) put_word(1'b0, pat_a(k) ^ s, 1'b0);
    for (int k = 0; k < 256; k++) put_word(1'b1, pat_b(k, s), 1'b0);
  endtask

  // Accelerator stub plus scoreboard-driven drain. Called on the falling
  // edge one cycle after the start pulse.
  task automatic run_drain(input bit bp, input bit ramp);
    int guard = 0;
    int idx = 0;
    bit stalled = 0;
    logic [31:0] held = '0;
    logic [31:0] e;
    repeat (8) @(negedge clk);
    tests++;
    if (rd_valid !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL wait_state: rd_valid=%b busy=%b, required 0 1", rd_valid, busy);
    end
    for (int i = 0; i < 1024; i++) acc_out[i] = ramp ? i[7:0] : 8'($urandom);
    for (int w = 0; w < 256; w++) exp_q.push_back(acc_out[w*4 +: 4]);
    acc_done = 1'b1;
    @(negedge clk);
    acc_done = 1'b0;
`ifdef ACC_LOADER_RESULT_BUF_EN
    acc_out = ~acc_out;
`endif
    tests++;
    if (rd_valid !== 1'b1) begin
      fails++;
      $display("FAIL rd_valid_latency: rd_valid=%b, required 1", rd_valid);
    end
    while (exp_q.size() > 0 && guard < 3000) begin
      if (stalled) begin
        tests++;
        if (rd_data !== held || rd_valid !== 1'b1) begin
          fails++;
          $display("FAIL stall_hold: rd_data=%h rd_valid=%b, required %h 1", rd_data, rd_valid, held);
        end
      end
      rd_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rd_valid === 1'b1 && rd_ready) begin
        e = exp_q.pop_front();
        tests++;
        if (rd_data !== e) begin
          fails++;
          $display("FAIL rd_data[%0d]: got %h, required %h", idx, rd_data, e);
        end
        tests++;
        if (rd_last !== (exp_q.size() == 0)) begin
          fails++;
          $display("FAIL rd_last[%0d]: got %b, required %b", idx, rd_last, (exp_q.size() == 0));
        end
        if (ramp && idx == 0) begin
          tests++;
          if (rd_data !== 32'h03020100) begin
            fails++;
            $display("FAIL ramp_first: got %h, required 03020100", rd_data);
          end
        end
        if (ramp && idx == 255) begin
          tests++;
          if (rd_data !== 32'hFFFEFDFC) begin
            fails++;
            $display("FAIL ramp_last: got %h, required fffefdfc", rd_data);
          end
        end
        idx++;
        stalled = 0;
      end else begin
        stalled = (rd_valid === 1'b1);
        held = rd_data;
      end
      @(negedge clk);
      guard++;
    end
    rd_ready = 1'b0;
    tests++;
    if (guard >= 3000) begin
      fails++;
      $display("FAIL drain_timeout: %0d words left, required 0", exp_q.size());
      exp_q.delete();
    end
    tests++;
    if (evt_done !== 1'b1 || rd_valid !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL drain_end: evt_done=%b rd_valid=%b busy=%b, required 1 0 0", evt_done, rd_valid, busy);
    end
    @(negedge clk);
    tests++;
    if (evt_done !== 1'b0 || wr_ready !== 1'b1) begin
      fails++;
      $display("FAIL evt_done_pulse: evt_done=%b wr_ready=%b, required 0 1", evt_done, wr_ready);
    end
    mptr_a = 0; mptr_b = 0;
  endtask

  task automatic test_reset();
    int bad = -1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    tests++;
    if ({wr_ready, rd_valid, rd_last, acc_start, busy, evt_done} !== 6'b0) begin
      fails++;
      $display("FAIL reset_ctrl: {wr_ready,rd_valid,rd_last,acc_start,busy,evt_done}=%b, required 000000",
               {wr_ready, rd_valid, rd_last, acc_start, busy, evt_done});
    end
    tests++;
    if (rd_data !== 32'h0) begin
      fails++;
      $display("FAIL reset_rd_data: got %h, required 0", rd_data);
    end
    tests++;
    for (int i = 0; i < 1024; i++) if (bad < 0 && (acc_in_A[i] !== 8'h0 || acc_in_B[i] !== 8'h0)) bad = i;
    if (bad >= 0) begin
      fails++;
      $display("FAIL reset_buffers: byte %0d A=%h B=%h, required 00", bad, acc_in_A[bad], acc_in_B[bad]);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    tests++;
    if (wr_ready !== 1'b0) begin
      fails++;
      $display("FAIL ready_before_edge: wr_ready=%b, required 0", wr_ready);
    end
    @(negedge clk);
    tests++;
    if (wr_ready !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL ready_after_edge: wr_ready=%b busy=%b, required 1 0", wr_ready, busy);
    end
  endtask

  task automatic test_seq_load();
    int bad = -1;
    stall_cnt = 0;
    for (int k = 0; k < 256; k++) put_word(1'b0, pat_a(k), 1'b0);
    for (int k = 0; k < 255; k++) put_word(1'b1, pat_b(k, 0), 1'b0);
    tests++;
    if (acc_start !== 1'b0) begin
      fails++;
      $display("FAIL seq_start_early: acc_start=%b, required 0", acc_start);
    end
    put_word(1'b1, pat_b(255, 0), 1'b0);
    tests++;
    if (acc_start !== 1'b1) begin
      fails++;
      $display("FAIL seq_start: acc_start=%b, required 1", acc_start);
    end
    // Word 0 = 0x01020304, word 1 = 0x01010101 + 0x01020304 = 0x02030405.
    tests++;
    if ({acc_in_A[7], acc_in_A[4], acc_in_A[3], acc_in_A[0]} !== 32'h02050104) begin
      fails++;
      $display("FAIL seq_lane_bytes: A[7,4,3,0]=%h, required 02050104",
               {acc_in_A[7], acc_in_A[4], acc_in_A[3], acc_in_A[0]});
    end
    tests++;
    for (int i = 0; i < 1024; i++) if (bad < 0 && (acc_in_A[i] !== model_a[i] || acc_in_B[i] !== model_b[i])) bad = i;
    if (bad >= 0) begin
      fails++;
      $display("FAIL seq_buffers: byte %0d A=%h B=%h, required %h %h", bad, acc_in_A[bad], acc_in_B[bad], model_a[bad], model_b[bad]);
    end
    tests++;
    if (stall_cnt !== 0) begin
      fails++;
      $display("FAIL seq_stalls: %0d stalled words, required 0", stall_cnt);
    end
    @(negedge clk);
    tests++;
    if (acc_start !== 1'b0) begin
      fails++;
      $display("FAIL seq_start_width: acc_start=%b, required 0", acc_start);
    end
    run_drain(1'b0, 1'b1);
  endtask

  task automatic test_interleave();
    int bad = -1;
    stall_cnt = 0;
    for (int k = 0; k < 256; k++) begin
      put_word(1'b0, pat_b(k, 7), 1'b0);
      if (k == 255) begin
        tests++;
        if (acc_start !== 1'b0) begin
          fails++;
          $display("FAIL il_start_early: acc_start=%b, required 0", acc_start);
        end
      end
      put_word(1'b1, pat_a(k) ^ 32'hFFFF0000, 1'b0);
    end
    tests++;
    if (acc_start !== 1'b1 || stall_cnt !== 0) begin
      fails++;
      $display("FAIL il_start: acc_start=%b stalls=%0d, required 1 0", acc_start, stall_cnt);
    end
    tests++;
    for (int i = 0; i < 1024; i++) if (bad < 0 && (acc_in_A[i] !== model_a[i] || acc_in_B[i] !== model_b[i])) bad = i;
    if (bad >= 0) begin
      fails++;
      $display("FAIL il_buffers: byte %0d A=%h B=%h, required %h %h", bad, acc_in_A[bad], acc_in_B[bad], model_a[bad], model_b[bad]);
    end
    @(negedge clk);
    run_drain(1'b1, 1'b0);
  endtask

  task automatic test_wr_last();
    int bad = -1;
    logic [1023:0][7:0] prev_a;
    prev_a = model_a;
    for (int k = 0; k < 4; k++) put_word(1'b0, 32'hC0DE0000 + k, (k == 3));
    tests++;
    if (wr_sel !== 1'b0 || wr_ready !== 1'b0) begin
      fails++;
      $display("FAIL last_a_full: wr_ready=%b, required 0", wr_ready);
    end
    for (int k = 0; k < 256; k++) put_word(1'b1, pat_b(k, 3), 1'b0);
    tests++;
    if (acc_start !== 1'b1) begin
      fails++;
      $display("FAIL last_start: acc_start=%b, required 1", acc_start);
    end
    tests++;
    for (int i = 16; i < 1024; i++) if (bad < 0 && acc_in_A[i] !== prev_a[i]) bad = i;
    if (bad >= 0) begin
      fails++;
      $display("FAIL last_a_untouched: byte %0d got %h, required %h", bad, acc_in_A[bad], prev_a[bad]);
    end
    tests++;
    if (acc_in_A[15:0] !== model_a[15:0]) begin
      fails++;
      $display("FAIL last_a_head: got %h, required %h", acc_in_A[15:0], model_a[15:0]);
    end
    @(negedge clk);
    run_drain(1'b1, 1'b1);
  endtask

  task automatic test_reset_mid();
    int bad;
    for (int ph = 0; ph < 2; ph++) begin
      load_full(ph + 11);
      @(negedge clk);
      if (ph == 0) begin
        repeat (3) @(negedge clk);
      end else begin
        for (int i = 0; i < 1024; i++) acc_out[i] = i[7:0];
        acc_done = 1'b1;
        @(negedge clk);
        acc_done = 1'b0;
        rd_ready = 1'b1;
        repeat (100) @(negedge clk);
      end
      #2 rst = 1'b1;
      #1;
      tests++;
      if ({wr_ready, rd_valid, rd_last, acc_start, busy, evt_done} !== 6'b0 || rd_data !== 32'h0) begin
        fails++;
        $display("FAIL mid_reset_ctrl[%0d]: ctrl=%b rd_data=%h, required 000000 0", ph,
                 {wr_ready, rd_valid, rd_last, acc_start, busy, evt_done}, rd_data);
      end
      bad = -1;
      tests++;
      for (int i = 0; i < 1024; i++) if (bad < 0 && (acc_in_A[i] !== 8'h0 || acc_in_B[i] !== 8'h0)) bad = i;
      if (bad >= 0) begin
        fails++;
        $display("FAIL mid_reset_buffers[%0d]: byte %0d A=%h B=%h, required 00", ph, bad, acc_in_A[bad], acc_in_B[bad]);
      end
      rd_ready = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      model_a = '0; model_b = '0; mptr_a = 0; mptr_b = 0;
      exp_q.delete();
      @(negedge clk);
      tests++;
      if (wr_ready !== 1'b1 || busy !== 1'b0) begin
        fails++;
        $display("FAIL mid_reset_recover[%0d]: wr_ready=%b busy=%b, required 1 0", ph, wr_ready, busy);
      end
    end
  endtask

  task automatic test_back_to_back();
    int bad = -1;
    load_full(5);
    tests++;
    if (acc_start !== 1'b1) begin
      fails++;
      $display("FAIL b2b_start: acc_start=%b, required 1", acc_start);
    end
    tests++;
    for (int i = 0; i < 1024; i++) if (bad < 0 && (acc_in_A[i] !== model_a[i] || acc_in_B[i] !== model_b[i])) bad = i;
    if (bad >= 0) begin
      fails++;
      $display("FAIL b2b_buffers: byte %0d A=%h B=%h, required %h %h", bad, acc_in_A[bad], acc_in_B[bad], model_a[bad], model_b[bad]);
    end
    @(negedge clk);
    run_drain(1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_seq_load();
    test_interleave();
    test_wr_last();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
